// File: rtl/speed_bar_ctrl.sv
// speed_bar_ctrl
//   Frame-synchronous animation controller for the speed-bar overlay stage.
//   It detects the start of each frame from the scan position, divides frame
//   starts down to an animate tick, and ramps the bar width toward a requested
//   speed by a fixed step per tick. The bar rectangle corners are registered
//   and change only at animation time, so a frame is never drawn half old/half new.
//
// Optional feature:
//   SPEED_BAR_DECAY_EN - when defined, dropping i_go forces the target to 0 on
//   each animate tick and the bar shrinks away by STEP per tick. When not
//   defined, dropping i_go freezes width and target where they are.
//
// Ports:
//   i_clk       pixel clock
//   i_rst       asynchronous, active-high reset
//   i_x, i_y    current scan position (12 bits each)
//   i_go        animation enable (level)
//   i_speed     requested bar width in pixels (sampled only on animate ticks)
//   o_animate   one-cycle animate tick
//   o_width     current animated width
//   o_at_tgt    width equals the latched target
//   o_x1, o_x2  bar left/right edges
//   o_y1, o_y2  bar top/bottom edges

module speed_bar_ctrl #(
  parameter int IX        = 515,
  parameter int IY        = 351,
  parameter int H_HIGHT   = 74,
  parameter int MAX_WIDTH = 200,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic        i_go,
  input  logic [7:0]  i_speed,
  output logic        o_animate,
  output logic [7:0]  o_width,
  output logic        o_at_tgt,
  output logic [11:0] o_x1,
  output logic [11:0] o_x2,
  output logic [11:0] o_y1,
  output logic [11:0] o_y2
);

  localparam logic [11:0] IX_C     = 12'(IX);
  localparam logic [11:0] IY_C     = 12'(IY);
  localparam logic [11:0] Y2_C     = 12'(IY + H_HIGHT);
  localparam logic [7:0]  MAX_C    = 8'(MAX_WIDTH);
  localparam logic [8:0]  STEP9    = 9'(STEP);
  localparam logic [7:0]  STEP8    = 8'(STEP);
  localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        pos_zero;
  logic        pos_zero_q;
  logic        fsync;
  logic [3:0]  div_cnt;
  logic        eval;
  logic [7:0]  target;
  logic [7:0]  target_nxt;
  logic [7:0]  width_nxt;
  logic [7:0]  speed_clamped;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [7:0]  up_val;
  logic [7:0]  dn_val;
  logic [7:0]  toward;
  state_t      toward_state;

  assign pos_zero = (i_x == 12'd0) && (i_y == 12'd0);

  // Frame start is the rising edge of the (0,0) compare, so holding the scan
  // at the origin for several cycles still yields a single fsync.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pos_zero_q <= 1'b0;
      fsync      <= 1'b0;
    end else begin
      pos_zero_q <= pos_zero;
      fsync      <= pos_zero & ~pos_zero_q;
    end
  end

  // Count frame starts; the animate tick fires after every FRAME_DIV-th one.
  // eval is the tick delayed by a cycle so the FSM sees the freshly latched target.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt   <= 4'd0;
      o_animate <= 1'b0;
      eval      <= 1'b0;
    end else begin
      eval      <= o_animate;
      o_animate <= 1'b0;
      if (fsync) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt   <= 4'd0;
          o_animate <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 4'd1;
        end
      end
    end
  end

  // Target is only ever updated on the animate tick, so i_speed changing
  // mid-frame has no effect until the next tick.
  always_comb begin
    speed_clamped = (i_speed > MAX_C) ? MAX_C : i_speed;
    target_nxt    = target;
    if (o_animate) begin
      if (i_go) begin
        target_nxt = speed_clamped;
      end
`ifdef SPEED_BAR_DECAY_EN
      else begin
        target_nxt = 8'd0;
      end
`endif
    end
  end

  // One step toward the target, computed 9 bits wide so neither direction can
  // wrap or overshoot; the step saturates exactly at the target.
  always_comb begin
    sum9   = {1'b0, o_width} + STEP9;
    diff9  = {1'b0, o_width} - {1'b0, target};
    up_val = (sum9 >= {1'b0, target}) ? target : sum9[7:0];
    dn_val = (diff9 <= STEP9) ? target : (o_width - STEP8);
    if (o_width < target) begin
      toward = up_val;
    end else if (o_width > target) begin
      toward = dn_val;
    end else begin
      toward = o_width;
    end
    if (toward == target) begin
      toward_state = HOLD;
    end else if (o_width < target) begin
      toward_state = UP;
    end else begin
      toward_state = DOWN;
    end
  end

  // The FSM only moves on the eval cycle. With i_go high every state steps
  // toward the target. With i_go low an in-flight UP/DOWN step still
  // completes before parking in IDLE; under decay every state keeps
  // stepping toward the forced-zero target.
  always_comb begin
    state_nxt = state;
    width_nxt = o_width;
    if (eval) begin
      if (i_go) begin
        width_nxt = toward;
        state_nxt = toward_state;
      end else begin
`ifdef SPEED_BAR_DECAY_EN
        width_nxt = toward;
        state_nxt = IDLE;
`else
        case (state)
          UP, DOWN: begin
            width_nxt = toward;
            state_nxt = IDLE;
          end
          default: begin
            state_nxt = IDLE;
          end
        endcase
`endif
      end
    end
  end

  // All outputs are registered together so the rectangle edges always agree
  // with o_width in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      o_width  <= 8'd0;
      target   <= 8'd0;
      o_at_tgt <= 1'b1;
      o_x1     <= IX_C;
      o_x2     <= IX_C;
      o_y1     <= IY_C;
      o_y2     <= Y2_C;
    end else begin
      state    <= state_nxt;
      o_width  <= width_nxt;
      target   <= target_nxt;
      o_at_tgt <= (width_nxt == target_nxt);
      o_x1     <= IX_C;
      o_x2     <= IX_C + {4'd0, width_nxt};
      o_y1     <= IY_C;
      o_y2     <= Y2_C;
    end
  end

endmodule

// File: tb/tb_speed_bar_ctrl.sv
// tb_speed_bar_ctrl
//   Directed bench for speed_bar_ctrl. Three instances share all inputs:
//   dutA with default parameters, dutB with STEP=3 and dutC with FRAME_DIV=3.
//   Expected values are hand-computed constants.

module tb_speed_bar_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] xPos;
  logic [11:0] yPos;
  logic        go;
  logic [7:0]  speed;

  logic        animA, animB, animC;
  logic [7:0]  widthA, widthB, widthC;
  logic        atTgtA, atTgtB, atTgtC;
  logic [11:0] x1A, x2A, y1A, y2A;
  logic [11:0] x1B, x2B, y1B, y2B;
  logic [11:0] x1C, x2C, y1C, y2C;

  int cmpCount = 0;
  int errCount = 0;
  int animCntA = 0;
  int animCntC = 0;
  int baseA;
  int baseC;

`ifdef SPEED_BAR_DECAY_EN
  int decayExpA[3] = '{4, 2, 0};
  int decayExpB    = 0;
`else
  int decayExpA[3] = '{6, 6, 6};
  int decayExpB    = 6;
`endif
  int rampExpA[5] = '{2, 4, 6, 8, 10};
  int downExpA[3] = '{48, 46, 45};

  speed_bar_ctrl dutA (
    .i_clk(clk), .i_rst(rst), .i_x(xPos), .i_y(yPos), .i_go(go), .i_speed(speed),
    .o_animate(animA), .o_width(widthA), .o_at_tgt(atTgtA),
    .o_x1(x1A), .o_x2(x2A), .o_y1(y1A), .o_y2(y2A)
  );

  speed_bar_ctrl #(.STEP(3)) dutB (
    .i_clk(clk), .i_rst(rst), .i_x(xPos), .i_y(yPos), .i_go(go), .i_speed(speed),
    .o_animate(animB), .o_width(widthB), .o_at_tgt(atTgtB),
    .o_x1(x1B), .o_x2(x2B), .o_y1(y1B), .o_y2(y2B)
  );

  speed_bar_ctrl #(.FRAME_DIV(3)) dutC (
    .i_clk(clk), .i_rst(rst), .i_x(xPos), .i_y(yPos), .i_go(go), .i_speed(speed),
    .o_animate(animC), .o_width(widthC), .o_at_tgt(atTgtC),
    .o_x1(x1C), .o_x2(x2C), .o_y1(y1C), .o_y2(y2C)
  );

  // Free-running pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count animate cycles away from the active edge; a stretched pulse would
  // show up as more than one count per tick.
  always @(negedge clk) begin
    if (animA === 1'b1) animCntA = animCntA + 1;
    if (animC === 1'b1) animCntC = animCntC + 1;
  end

  task automatic applyStimulus(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    xPos = x;
    yPos = y;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: origin for a cycle, then away long enough for the tick,
  // the target latch and the width update to land.
  task automatic runFrame();
    applyStimulus(12'd0, 12'd0);
    applyStimulus(12'd100, 12'd100);
    repeat (3) @(negedge clk);
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) runFrame();
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst   = 1'b1;
    xPos  = 12'd100;
    yPos  = 12'd100;
    go    = 1'b0;
    speed = 8'd0;

    @(negedge clk);
    checkOutput("rst_width", 32'(widthA), 32'd0);
    checkOutput("rst_at_tgt", 32'(atTgtA), 32'd1);
    checkOutput("rst_animate", 32'(animA), 32'd0);
    checkOutput("rst_x1", 32'(x1A), 32'd515);
    checkOutput("rst_x2", 32'(x2A), 32'd515);
    checkOutput("rst_y1", 32'(y1A), 32'd351);
    checkOutput("rst_y2", 32'(y2A), 32'd425);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] ramp up to 10");
    go    = 1'b1;
    speed = 8'd10;
    for (int i = 0; i < 5; i++) begin
      runFrame();
      checkOutput("ramp_width", 32'(widthA), 32'(rampExpA[i]));
      if (i == 0) checkOutput("ramp_at_tgt_busy", 32'(atTgtA), 32'd0);
    end
    checkOutput("ramp_at_tgt_done", 32'(atTgtA), 32'd1);
    checkOutput("ramp_x2", 32'(x2A), 32'd525);
    checkOutput("ramp_b_width", 32'(widthB), 32'd10);

    $display("[TB] ramp to 50 then down to 45");
    speed = 8'd50;
    runFrames(20);
    checkOutput("to50_width", 32'(widthA), 32'd50);
    checkOutput("to50_b_width", 32'(widthB), 32'd50);
    speed = 8'd45;
    for (int i = 0; i < 3; i++) begin
      runFrame();
      checkOutput("down_width", 32'(widthA), 32'(downExpA[i]));
    end
    checkOutput("down_b_width", 32'(widthB), 32'd45);

    $display("[TB] settle at 6 then drop go");
    speed = 8'd6;
    runFrames(22);
    checkOutput("to6_width", 32'(widthA), 32'd6);
    checkOutput("to6_b_width", 32'(widthB), 32'd6);
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      runFrame();
      checkOutput("go_low_width", 32'(widthA), 32'(decayExpA[i]));
    end
    checkOutput("go_low_b_width", 32'(widthB), 32'(decayExpB));

    $display("[TB] clamp at MAX_WIDTH");
    go    = 1'b1;
    speed = 8'd255;
    runFrames(105);
    checkOutput("clamp_width", 32'(widthA), 32'd200);
    checkOutput("clamp_x2", 32'(x2A), 32'd715);
    checkOutput("clamp_at_tgt", 32'(atTgtA), 32'd1);
    checkOutput("clamp_b_width", 32'(widthB), 32'd200);
    checkOutput("clamp_b_x2", 32'(x2B), 32'd715);

    $display("[TB] reset mid-ramp");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    speed = 8'd100;
    runFrames(20);
    checkOutput("pre_rst_width", 32'(widthA), 32'd40);
    checkOutput("pre_rst_x2", 32'(x2A), 32'd555);
    checkOutput("pre_rst_b_width", 32'(widthB), 32'd60);
    checkOutput("pre_rst_c_width", 32'(widthC), 32'd12);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_width", 32'(widthA), 32'd0);
    checkOutput("async_rst_x2", 32'(x2A), 32'd515);
    checkOutput("async_rst_at_tgt", 32'(atTgtA), 32'd1);
    checkOutput("async_rst_animate", 32'(animA), 32'd0);
    checkOutput("async_rst_b_width", 32'(widthB), 32'd0);
    checkOutput("async_rst_c_width", 32'(widthC), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] divider");
    @(negedge clk);
    baseA = animCntA;
    baseC = animCntC;
    runFrames(2);
    checkOutput("div_after2", 32'(animCntC - baseC), 32'd0);
    runFrame();
    checkOutput("div_after3", 32'(animCntC - baseC), 32'd1);
    runFrames(6);
    checkOutput("div_after9", 32'(animCntC - baseC), 32'd3);
    checkOutput("div1_after9", 32'(animCntA - baseA), 32'd9);

    $display("[TB] origin held 5 cycles");
    baseA = animCntA;
    applyStimulus(12'd0, 12'd0);
    repeat (4) @(negedge clk);
    applyStimulus(12'd100, 12'd100);
    repeat (3) @(negedge clk);
    checkOutput("hold_origin_ticks", 32'(animCntA - baseA), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
